// File: rtl/memory_bus_write_decoder_pkg.sv
// Shared constants for the CPU memory-bus write decoder: BRAM region select
// codes, page/segment register addresses and the bus-write FSM state type.
package memory_bus_write_decoder_pkg;

    localparam logic [1:0] BRAM_SELECT_CONTROLLER = 2'd0;
    localparam logic [1:0] BRAM_SELECT_MOD        = 2'd1;
    localparam logic [1:0] BRAM_SELECT_DUTY_TABLE = 2'd2;
    localparam logic [1:0] BRAM_SELECT_STM        = 2'd3;

    // Controller-space addresses that also load the address-extension registers.
    localparam logic [13:0] ADDR_MOD_MEM_WR_SEGMENT                = 14'h0020;
    localparam logic [13:0] ADDR_STM_MEM_WR_SEGMENT                = 14'h0021;
    localparam logic [13:0] ADDR_STM_MEM_WR_PAGE                   = 14'h0022;
    localparam logic [13:0] ADDR_PULSE_WIDTH_ENCODER_TABLE_WR_PAGE = 14'h0023;

    typedef enum logic [1:0] {
        BUS_WR_IDLE   = 2'd0,
        BUS_WR_COMMIT = 2'd1,
        BUS_WR_HOLD   = 2'd2
    } bus_wr_state_t;

endpackage

// File: rtl/memory_bus_write_decoder.sv
// Receiving end of the CPU memory bus. Registers the bus pins, turns each
// CPU write cycle into exactly one single-cycle strobe on one of four BRAM
// ports and holds the segment/page registers that widen the 14-bit address.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a sampled EN=WE=1
// COMMIT | strobe high for one cycle, page registers updated at its end
// HOLD   | write already issued, waiting for WE or EN to drop
module memory_bus_write_decoder
    import memory_bus_write_decoder_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        WE,
    input  logic [1:0]  BRAM_SELECT,
    input  logic [13:0] BRAM_ADDR,
    input  logic [15:0] DATA_IN,
    output logic [15:0] WR_DATA,
    output logic        CNT_WE,
    output logic [13:0] CNT_ADDR,
    output logic        MOD_WE,
    output logic [14:0] MOD_ADDR,
    output logic        DUTY_WE,
    output logic [14:0] DUTY_ADDR,
    output logic        STM_WE,
    output logic [18:0] STM_ADDR,
    output logic [15:0] WR_COUNT
);

    logic          s1_en;
    logic          s1_we;
    logic [1:0]    s1_sel;
    logic [13:0]   s1_addr;
    logic [15:0]   s1_data;

    bus_wr_state_t state;
    logic          lat_is_ctrl;
    logic [13:0]   lat_addr;
    logic [3:0]    lat_data;

    logic          mod_segment;
    logic          stm_segment;
    logic [3:0]    stm_page;
    logic          duty_page;

    logic          s1_write;

    assign s1_write = s1_en & s1_we;

    // Input stage: every bus pin is registered once before any decoding.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_en   <= 1'b0;
            s1_we   <= 1'b0;
            s1_sel  <= '0;
            s1_addr <= '0;
            s1_data <= '0;
        end else begin
            s1_en   <= EN;
            s1_we   <= WE;
            s1_sel  <= BRAM_SELECT;
            s1_addr <= BRAM_ADDR;
            s1_data <= DATA_IN;
        end
    end

    // Write FSM plus registered strobes, addresses, data and commit counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= BUS_WR_IDLE;
            lat_is_ctrl <= 1'b0;
            lat_addr    <= '0;
            lat_data    <= '0;
            WR_DATA     <= '0;
            CNT_WE      <= 1'b0;
            CNT_ADDR    <= '0;
            MOD_WE      <= 1'b0;
            MOD_ADDR    <= '0;
            DUTY_WE     <= 1'b0;
            DUTY_ADDR   <= '0;
            STM_WE      <= 1'b0;
            STM_ADDR    <= '0;
            WR_COUNT    <= '0;
        end else begin
            CNT_WE  <= 1'b0;
            MOD_WE  <= 1'b0;
            DUTY_WE <= 1'b0;
            STM_WE  <= 1'b0;
            case (state)
                BUS_WR_IDLE: begin
                    if (s1_write) begin
                        state       <= BUS_WR_COMMIT;
                        lat_is_ctrl <= (s1_sel == BRAM_SELECT_CONTROLLER);
                        lat_addr    <= s1_addr;
                        lat_data    <= s1_data[3:0];
                        WR_DATA     <= s1_data;
                        WR_COUNT    <= WR_COUNT + 16'd1;
                        // Strobe and its address land together so the BRAM sees
                        // them in the same COMMIT cycle.
                        case (s1_sel)
                            BRAM_SELECT_CONTROLLER: begin
                                CNT_WE   <= 1'b1;
                                CNT_ADDR <= s1_addr;
                            end
                            BRAM_SELECT_MOD: begin
                                MOD_WE   <= 1'b1;
                                MOD_ADDR <= {mod_segment, s1_addr};
                            end
                            BRAM_SELECT_DUTY_TABLE: begin
                                DUTY_WE   <= 1'b1;
                                DUTY_ADDR <= {duty_page, s1_addr};
                            end
                            default: begin
                                STM_WE   <= 1'b1;
                                STM_ADDR <= {stm_segment, stm_page, s1_addr};
                            end
                        endcase
                    end
                end
                BUS_WR_COMMIT: begin
                    // Skipping HOLD when WE already dropped keeps a one-cycle
                    // WE gap from being swallowed as part of the previous write.
                    state <= s1_write ? BUS_WR_HOLD : BUS_WR_IDLE;
                end
                BUS_WR_HOLD: begin
                    if (!s1_write) state <= BUS_WR_IDLE;
                end
                default: state <= BUS_WR_IDLE;
            endcase
        end
    end

    // Address-extension registers load at the end of COMMIT, so they only
    // affect the following write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mod_segment <= 1'b0;
            stm_segment <= 1'b0;
            stm_page    <= '0;
            duty_page   <= 1'b0;
        end else if (state == BUS_WR_COMMIT && lat_is_ctrl) begin
            case (lat_addr)
                ADDR_MOD_MEM_WR_SEGMENT:                mod_segment <= lat_data[0];
                ADDR_STM_MEM_WR_SEGMENT:                stm_segment <= lat_data[0];
                ADDR_STM_MEM_WR_PAGE:                   stm_page    <= lat_data;
                ADDR_PULSE_WIDTH_ENCODER_TABLE_WR_PAGE: duty_page   <= lat_data[0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_write_decoder.sv
// Scoreboard bench for memory_bus_write_decoder: the driver pushes the
// expected commit for every bus write, a negedge monitor pops on each strobe.
module tb_memory_bus_write_decoder;
    import memory_bus_write_decoder_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic        WE = 1'b0;
    logic [1:0]  BRAM_SELECT = '0;
    logic [13:0] BRAM_ADDR = '0;
    logic [15:0] DATA_IN = '0;
    logic [15:0] WR_DATA;
    logic        CNT_WE;
    logic [13:0] CNT_ADDR;
    logic        MOD_WE;
    logic [14:0] MOD_ADDR;
    logic        DUTY_WE;
    logic [14:0] DUTY_ADDR;
    logic        STM_WE;
    logic [18:0] STM_ADDR;
    logic [15:0] WR_COUNT;

    memory_bus_write_decoder dut (
        .CLK(CLK), .RST(RST), .EN(EN), .WE(WE), .BRAM_SELECT(BRAM_SELECT),
        .BRAM_ADDR(BRAM_ADDR), .DATA_IN(DATA_IN), .WR_DATA(WR_DATA),
        .CNT_WE(CNT_WE), .CNT_ADDR(CNT_ADDR), .MOD_WE(MOD_WE), .MOD_ADDR(MOD_ADDR),
        .DUTY_WE(DUTY_WE), .DUTY_ADDR(DUTY_ADDR), .STM_WE(STM_WE), .STM_ADDR(STM_ADDR),
        .WR_COUNT(WR_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  sel;
        logic [18:0] addr;
        logic [15:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: extension registers and commit count.
    int   m_mod_seg = 0;
    int   m_stm_seg = 0;
    int   m_stm_page = 0;
    int   m_duty_page = 0;
    int   m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] model_addr(input logic [1:0] sel, input logic [13:0] a);
        int full;
        full = int'(a);
        case (sel)
            BRAM_SELECT_MOD:        full = full + m_mod_seg * 16384;
            BRAM_SELECT_DUTY_TABLE: full = full + m_duty_page * 16384;
            BRAM_SELECT_STM:        full = full + m_stm_page * 16384 + m_stm_seg * 262144;
            default: ;
        endcase
        return 19'(full);
    endfunction

    task automatic push_write(input logic [1:0] sel, input logic [13:0] a, input logic [15:0] d);
        exp_t e;
        m_cnt = (m_cnt + 1) % 65536;
        e.sel  = sel;
        e.addr = model_addr(sel, a);
        e.data = d;
        e.cnt  = 16'(m_cnt);
        q.push_back(e);
        if (sel == BRAM_SELECT_CONTROLLER) begin
            if (a == ADDR_MOD_MEM_WR_SEGMENT) m_mod_seg = d % 2;
            if (a == ADDR_STM_MEM_WR_SEGMENT) m_stm_seg = d % 2;
            if (a == ADDR_STM_MEM_WR_PAGE)    m_stm_page = d % 16;
            if (a == ADDR_PULSE_WIDTH_ENCODER_TABLE_WR_PAGE) m_duty_page = d % 2;
        end
    endtask

    // One bus write: WE held for 'hold' sampled edges (bus lines scrambled
    // after the first), then WE low for gap+1 sampled edges.
    task automatic do_write(input bit en_v, input logic [1:0] sel, input logic [13:0] a,
                            input logic [15:0] d, input int hold, input int gap);
        @(posedge CLK); #1;
        if (en_v) push_write(sel, a, d);
        EN = en_v; WE = 1'b1; BRAM_SELECT = sel; BRAM_ADDR = a; DATA_IN = d;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            if (i + 1 < hold) begin
                BRAM_SELECT = 2'($urandom);
                BRAM_ADDR   = 14'($urandom);
                DATA_IN     = 16'($urandom);
            end
        end
        WE = 1'b0; EN = 1'b0;
        repeat (gap) @(posedge CLK);
    endtask

    // Monitor: every strobe must be single, one cycle wide and match the queue head.
    bit prev_any = 1'b0;
    always @(negedge CLK) begin
        int n;
        exp_t e;
        logic [1:0]  a_sel;
        logic [18:0] a_addr;
        if (RST) begin
            prev_any = 1'b0;
        end else begin
            n = int'(CNT_WE) + int'(MOD_WE) + int'(DUTY_WE) + int'(STM_WE);
            if (n > 0) begin
                chk("strobe_width", 32'(prev_any), 32'd0);
                if (n > 1) chk("strobe_onehot", 32'(n), 32'd1);
                if (CNT_WE)       begin a_sel = BRAM_SELECT_CONTROLLER; a_addr = {5'd0, CNT_ADDR}; end
                else if (MOD_WE)  begin a_sel = BRAM_SELECT_MOD;        a_addr = {4'd0, MOD_ADDR}; end
                else if (DUTY_WE) begin a_sel = BRAM_SELECT_DUTY_TABLE; a_addr = {4'd0, DUTY_ADDR}; end
                else              begin a_sel = BRAM_SELECT_STM;        a_addr = STM_ADDR; end
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got sel %0d addr 0x%0h expected no strobe at %0t",
                             a_sel, a_addr, $time);
                end else begin
                    e = q.pop_front();
                    chk("sel",      32'(a_sel),    32'(e.sel));
                    chk("addr",     32'(a_addr),   32'(e.addr));
                    chk("wr_data",  32'(WR_DATA),  32'(e.data));
                    chk("wr_count", 32'(WR_COUNT), 32'(e.cnt));
                end
            end
            prev_any = (n > 0);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rs;
        logic [13:0] ra;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_cnt_we",   32'(CNT_WE),    32'd0);
        chk("rst_stm_we",   32'(STM_WE),    32'd0);
        chk("rst_wr_count", 32'(WR_COUNT),  32'd0);
        chk("rst_wr_data",  32'(WR_DATA),   32'd0);
        chk("rst_stm_addr", 32'(STM_ADDR),  32'd0);
        chk("rst_mod_addr", 32'(MOD_ADDR),  32'd0);
        @(negedge CLK); RST = 1'b0;

        // First write with explicit latency check.
        @(negedge CLK);
        fork
            do_write(1'b1, BRAM_SELECT_CONTROLLER, 14'h0012, 16'hBEEF, 3, 2);
            begin
                @(negedge CLK);
                @(negedge CLK); chk("latency_early", 32'(CNT_WE), 32'd0);
                @(negedge CLK); chk("latency_strobe", 32'(CNT_WE), 32'd1);
            end
        join

        do_write(1'b1, BRAM_SELECT_CONTROLLER, ADDR_MOD_MEM_WR_SEGMENT, 16'h0001, 1, 0);
        do_write(1'b1, BRAM_SELECT_MOD, 14'h0005, 16'h1234, 2, 1);
        do_write(1'b1, BRAM_SELECT_CONTROLLER, ADDR_STM_MEM_WR_SEGMENT, 16'h0001, 1, 0);
        do_write(1'b1, BRAM_SELECT_CONTROLLER, ADDR_STM_MEM_WR_PAGE, 16'h0003, 1, 0);
        do_write(1'b1, BRAM_SELECT_STM, 14'h0100, 16'h5A5A, 1, 1);
        do_write(1'b1, BRAM_SELECT_CONTROLLER, ADDR_PULSE_WIDTH_ENCODER_TABLE_WR_PAGE, 16'h0001, 1, 0);
        do_write(1'b1, BRAM_SELECT_DUTY_TABLE, 14'h3FFF, 16'hCAFE, 4, 1);

        // WE with EN low for 5 cycles must not commit.
        do_write(1'b0, BRAM_SELECT_STM, 14'h0042, 16'h0BAD, 5, 3);
        repeat (3) @(posedge CLK); #1;
        chk("en_low_count", 32'(WR_COUNT), 32'(m_cnt));

        // Reset during HOLD, with WE still high afterwards.
        @(posedge CLK); #1;
        push_write(BRAM_SELECT_CONTROLLER, 14'h0055, 16'hA5A5);
        EN = 1'b1; WE = 1'b1; BRAM_SELECT = BRAM_SELECT_CONTROLLER;
        BRAM_ADDR = 14'h0055; DATA_IN = 16'hA5A5;
        for (int i = 0; i < 10 && !CNT_WE; i++) @(negedge CLK);
        chk("rst_test_strobe_seen", 32'(CNT_WE), 32'd1);
        @(posedge CLK); @(posedge CLK); #2;
        RST = 1'b1; #1;
        chk("midrst_cnt_we",   32'(CNT_WE),   32'd0);
        chk("midrst_wr_count", 32'(WR_COUNT), 32'd0);
        chk("midrst_cnt_addr", 32'(CNT_ADDR), 32'd0);
        chk("midrst_wr_data",  32'(WR_DATA),  32'd0);
        m_mod_seg = 0; m_stm_seg = 0; m_stm_page = 0; m_duty_page = 0; m_cnt = 0;
        push_write(BRAM_SELECT_CONTROLLER, 14'h0055, 16'hA5A5);
        @(negedge CLK); @(negedge CLK); RST = 1'b0;
        repeat (5) @(posedge CLK); #1;
        WE = 1'b0; EN = 1'b0;
        repeat (2) @(posedge CLK);

        // Extension registers are back at zero after reset.
        do_write(1'b1, BRAM_SELECT_MOD, 14'h0005, 16'h1111, 1, 1);
        do_write(1'b1, BRAM_SELECT_STM, 14'h0100, 16'h2222, 1, 1);
        do_write(1'b1, BRAM_SELECT_DUTY_TABLE, 14'h3FFF, 16'h3333, 1, 1);

        // Randomized traffic, with extension-register writes mixed in.
        for (int k = 0; k < 1500; k++) begin
            rs = 2'($urandom);
            ra = 14'($urandom);
            if (rs == BRAM_SELECT_CONTROLLER && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 3))
                    0: ra = ADDR_MOD_MEM_WR_SEGMENT;
                    1: ra = ADDR_STM_MEM_WR_SEGMENT;
                    2: ra = ADDR_STM_MEM_WR_PAGE;
                    default: ra = ADDR_PULSE_WIDTH_ENCODER_TABLE_WR_PAGE;
                endcase
            end
            do_write($urandom_range(0, 9) != 0, rs, ra, 16'($urandom),
                     int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge CLK);
        chk("queue_drained", 32'(q.size()), 32'd0);
        repeat (2) @(negedge CLK);
        chk("final_count", 32'(WR_COUNT), 32'(m_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
